// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
package shifter_pkg;

    typedef enum logic [1:0] {
        OP_SRL = 2'b00,
        OP_SRA = 2'b01,
        OP_SLL = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

    // Widest operand the reversal helper can handle.
    localparam int MAX_W = 64;

    // Reverse the low w bits of d; bits at and above w come back as zero.
    function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] d, input int w);
        logic [MAX_W-1:0] r;
        r = {MAX_W{1'b0}};
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                r[i] = d[w-1-i];
            end else begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_stage.sv
// One pipeline stage: conditional right shift/rotate by DIST, then a register
// that also carries shamt, op and fill forward. Holds while en_i is low.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DIST    = 1,
    parameter int SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic               valid_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic               shamt_bit_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [1:0]         op_i,
    input  logic               fill_i,
    output logic               valid_o,
    output logic [WIDTH-1:0]   data_o,
    output logic [SHAMT_W-1:0] shamt_o,
    output logic [1:0]         op_o,
    output logic               fill_o
);

    logic [WIDTH-1:0]   shifted_s;
    logic               valid_d, valid_q;
    logic [WIDTH-1:0]   data_d, data_q;
    logic [SHAMT_W-1:0] shamt_d, shamt_q;
    logic [1:0]         op_d, op_q;
    logic               fill_d, fill_q;

    // Shift by DIST when this stage's shamt bit is set; ROR wraps, others use fill.
    always_comb begin
        shifted_s = data_i;
        if (shamt_bit_i) begin
            if (shift_op_e'(op_i) == OP_ROR) begin
                shifted_s = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
            end else begin
                shifted_s = {{DIST{fill_i}}, data_i[WIDTH-1:DIST]};
            end
        end else begin
            shifted_s = data_i;
        end
    end

    // Next-state: load a new beat (or bubble) when enabled, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        op_d    = op_q;
        fill_d  = fill_q;
        if (en_i) begin
            valid_d = valid_i;
            data_d  = shifted_s;
            shamt_d = shamt_i;
            op_d    = op_i;
            fill_d  = fill_i;
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
            shamt_d = shamt_q;
            op_d    = op_q;
            fill_d  = fill_q;
        end
    end

    // Stage register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= {WIDTH{1'b0}};
            shamt_q <= {SHAMT_W{1'b0}};
            op_q    <= 2'b00;
            fill_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            op_q    <= op_d;
            fill_q  <= fill_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign shamt_o = shamt_q;
    assign op_o    = op_q;
    assign fill_o  = fill_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: SRL/SRA/SLL/ROR over log2(WIDTH) registered stages
// with valid/ready handshakes. SLL runs as reverse -> SRL -> reverse.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter  int WIDTH   = 8,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
);

    logic               stall_s;
    logic               s0_valid_s;
    logic [WIDTH-1:0]   s0_data_s;
    logic               s0_fill_s;

    logic               stg_valid_s [0:SHAMT_W-1];
    logic [WIDTH-1:0]   stg_data_s  [0:SHAMT_W-1];
    logic [SHAMT_W-1:0] stg_shamt_s [0:SHAMT_W-1];
    logic [1:0]         stg_op_s    [0:SHAMT_W-1];
    logic               stg_fill_s  [0:SHAMT_W-1];

    // Handshake: the whole pipeline freezes while the output beat is refused.
    always_comb begin
        stall_s    = out_valid & ~out_ready;
        in_ready   = ~stall_s;
        s0_valid_s = in_valid & in_ready;
    end

    // Stage-0 operand prep: pre-reverse for SLL and capture the SRA sign fill.
    always_comb begin
        s0_data_s = in_data;
        s0_fill_s = 1'b0;
        if (shift_op_e'(in_op) == OP_SLL) begin
            s0_data_s = WIDTH'(bit_reverse(MAX_W'(in_data), WIDTH));
        end else begin
            s0_data_s = in_data;
        end
        if (shift_op_e'(in_op) == OP_SRA) begin
            s0_fill_s = in_data[WIDTH-1];
        end else begin
            s0_fill_s = 1'b0;
        end
    end

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        if (k == 0) begin : g_first
            shift_stage #(.WIDTH(WIDTH), .DIST(1), .SHAMT_W(SHAMT_W)) u_stage (
                .clk         (clk),
                .rst_n       (rst_n),
                .en_i        (~stall_s),
                .valid_i     (s0_valid_s),
                .data_i      (s0_data_s),
                .shamt_bit_i (in_shamt[0]),
                .shamt_i     (in_shamt),
                .op_i        (in_op),
                .fill_i      (s0_fill_s),
                .valid_o     (stg_valid_s[0]),
                .data_o      (stg_data_s[0]),
                .shamt_o     (stg_shamt_s[0]),
                .op_o        (stg_op_s[0]),
                .fill_o      (stg_fill_s[0])
            );
        end else begin : g_next
            shift_stage #(.WIDTH(WIDTH), .DIST(1 << k), .SHAMT_W(SHAMT_W)) u_stage (
                .clk         (clk),
                .rst_n       (rst_n),
                .en_i        (~stall_s),
                .valid_i     (stg_valid_s[k-1]),
                .data_i      (stg_data_s[k-1]),
                .shamt_bit_i (stg_shamt_s[k-1][k]),
                .shamt_i     (stg_shamt_s[k-1]),
                .op_i        (stg_op_s[k-1]),
                .fill_i      (stg_fill_s[k-1]),
                .valid_o     (stg_valid_s[k]),
                .data_o      (stg_data_s[k]),
                .shamt_o     (stg_shamt_s[k]),
                .op_o        (stg_op_s[k]),
                .fill_o      (stg_fill_s[k])
            );
        end
    end

    // Output side: undo the SLL reversal on the final stage's register.
    always_comb begin
        out_valid = stg_valid_s[SHAMT_W-1];
        if (shift_op_e'(stg_op_s[SHAMT_W-1]) == OP_SLL) begin
            out_data = WIDTH'(bit_reverse(MAX_W'(stg_data_s[SHAMT_W-1]), WIDTH));
        end else begin
            out_data = stg_data_s[SHAMT_W-1];
        end
    end

endmodule
